// File: rtl/mmio_io_pkg.sv
// Register map constants for the board-I/O MMIO window.
// Shared by mmio_io_ctrl; the optional IRQ_MASK register is enabled by MMIO_IO_IRQ_EN.
package mmio_io_pkg;

   localparam int OFFS_SW        = 'h00;
   localparam int OFFS_BTN_LEVEL = 'h10;
   localparam int OFFS_BTN_PRESS = 'h14;
   localparam int OFFS_IRQ_MASK  = 'h18;
   localparam int OFFS_LED       = 'h20;
   localparam int BANK_STRIDE    = 4;

   // Byte offset to 32-bit word index.
   function automatic int word_of(input int byte_offs);
      return byte_offs / BANK_STRIDE;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and debounced level.
// rise is combinational and marks the edge at which the level goes 0->1.
module io_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic [CW-1:0] cnt_reg;
   logic          differ;
   logic          expire;

   assign differ = sync2_reg != level_reg;
   // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
   assign expire = differ && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= pin;
         sync2_reg <= sync1_reg;
         if (!differ || expire)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + CW'(1);
         if (expire)
            level_reg <= ~level_reg;
      end
   end

   assign level = level_reg;
   assign rise  = expire && !level_reg;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO board-I/O controller: synchronised switches, debounced buttons with sticky press flags, LED banks.
// Define MMIO_IO_IRQ_EN to add the IRQ_MASK register and the irq output.
module mmio_io_ctrl
   import mmio_io_pkg::*;
#(
   parameter int NUM_SW_BANKS    = 1,
   parameter int NUM_BTN         = 1,
   parameter int NUM_LED_BANKS   = 1,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int OFFS_W          = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [8*NUM_SW_BANKS-1:0]  Switch,
   input  logic [NUM_BTN-1:0]         Button,
   output logic [8*NUM_LED_BANKS-1:0] Led,
   input  logic [OFFS_W-1:0]          offs,
   input  logic                       we,
   input  logic [31:0]                wdata,
   input  logic                       re,
   output logic [31:0]                rdata,
   output logic                       rvalid
`ifdef MMIO_IO_IRQ_EN
   ,
   output logic                       irq
`endif
);

   logic [8*NUM_SW_BANKS-1:0]       sw_sync1_reg;
   logic [8*NUM_SW_BANKS-1:0]       sw_sync2_reg;
   logic [NUM_BTN-1:0]              btn_level;
   logic [NUM_BTN-1:0]              btn_rise;
   logic [NUM_BTN-1:0]              press_reg;
   logic [NUM_BTN-1:0]              w1c;
   logic [NUM_LED_BANKS-1:0][7:0]   led_reg;
   logic [OFFS_W-3:0]               word_addr;
   int                              word_idx;
   logic [31:0]                     rd_mux;
   logic [31:0]                     rd_data_reg;
   logic [31:0]                     rdata_reg;
   logic                            rd_pend_reg;
   logic                            rvalid_reg;
   logic                            unused_bits;

   assign word_addr   = offs[OFFS_W-1:2];
   assign word_idx    = int'(word_addr);
   assign unused_bits = ^{offs[1:0], wdata[31:8]};

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      io_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .reset(reset),
         .pin  (Button[gi]),
         .level(btn_level[gi]),
         .rise (btn_rise[gi])
      );
   end

   assign w1c = (we && word_idx == word_of(OFFS_BTN_PRESS)) ? wdata[NUM_BTN-1:0] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_sync1_reg <= '0;
         sw_sync2_reg <= '0;
         press_reg    <= '0;
         led_reg      <= '0;
      end else begin
         sw_sync1_reg <= Switch;
         sw_sync2_reg <= sw_sync1_reg;
         // A rise on the same edge as its W1C keeps the flag set.
         press_reg    <= (press_reg & ~w1c) | btn_rise;
         for (int i = 0; i < NUM_LED_BANKS; i++) begin
            if (we && word_idx == word_of(OFFS_LED) + i)
               led_reg[i] <= wdata[7:0];
         end
      end
   end

   assign Led = led_reg;

`ifdef MMIO_IO_IRQ_EN
   logic [NUM_BTN-1:0] mask_reg;
   logic               irq_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_reg <= '0;
         irq_reg  <= 1'b0;
      end else begin
         if (we && word_idx == word_of(OFFS_IRQ_MASK))
            mask_reg <= wdata[NUM_BTN-1:0];
         irq_reg <= |(press_reg & mask_reg);
      end
   end

   assign irq = irq_reg;
`endif

   // Read mux sees pre-write state, so a simultaneous write/read returns the old value.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_SW_BANKS; i++) begin
         if (word_idx == word_of(OFFS_SW) + i)
            rd_mux[7:0] = sw_sync2_reg[8*i +: 8];
      end
      for (int i = 0; i < NUM_LED_BANKS; i++) begin
         if (word_idx == word_of(OFFS_LED) + i)
            rd_mux[7:0] = led_reg[i];
      end
      if (word_idx == word_of(OFFS_BTN_LEVEL))
         rd_mux[NUM_BTN-1:0] = btn_level;
      if (word_idx == word_of(OFFS_BTN_PRESS))
         rd_mux[NUM_BTN-1:0] = press_reg;
`ifdef MMIO_IO_IRQ_EN
      if (word_idx == word_of(OFFS_IRQ_MASK))
         rd_mux[NUM_BTN-1:0] = mask_reg;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pend_reg <= 1'b0;
         rd_data_reg <= '0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         rd_pend_reg <= re;
         if (re)
            rd_data_reg <= rd_mux;
         rvalid_reg <= rd_pend_reg;
         if (rd_pend_reg)
            rdata_reg <= rd_data_reg;
      end
   end

   assign rdata  = rdata_reg;
   assign rvalid = rvalid_reg;

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Parametrised memory-mapped board-I/O controller between the CPU data bus and the switch/button/LED pins.
- Generalises the single 8-bit switch bank, single button and single LED bank to N banks/buttons.
- Adds input synchronisation, button debounce, sticky press flags and a registered read port.
- Sits on the uncached MMIO path of the CPU, decoded by the top-level address mux.

Parameters:
NUM_SW_BANKS, 1, number of 8-bit switch banks (1..4)
NUM_BTN, 1, number of push buttons (1..8)
NUM_LED_BANKS, 1, number of 8-bit LED banks (1..4)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button change (>=2)
OFFS_W, 6, width of the byte-offset bus

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Switch  in  8*NUM_SW_BANKS  raw switch pins, bank i = bits [8i+7:8i]
Button  in  NUM_BTN  raw button pins, active-high
Led  out  8*NUM_LED_BANKS  LED register outputs
offs  in  OFFS_W  byte offset within the MMIO window (bits [1:0] ignored)
we  in  1  write strobe, one cycle
wdata  in  32  write data
re  in  1  read strobe, one cycle
rdata  out  32  read data
rvalid  out  1  read data valid

Behaviour:
- Reset (reset=0, asynchronous): Led=0, rdata=0, rvalid=0, all synchronisers=0, debounced levels=0, press flags=0, counters=0.
- Register map (word offsets):
  - 0x00+4i: SW[i], RO. Synchronised switch bank i in bits [7:0]; other bits read 0.
  - 0x10: BTN_LEVEL, RO. Debounced levels in bits [NUM_BTN-1:0].
  - 0x14: BTN_PRESS, W1C. Sticky rising-edge flags.
  - 0x20+4i: LED[i], RW. Only bits [7:0] are stored.
  - Unmapped offsets, or bank index >= parameter count: reads return 0; writes are ignored.
- Switch inputs: 2-flop synchroniser, no debounce. A pin change is visible in SW reads at the 2nd clock edge after the change.
- Buttons (per channel):
  - 2-flop synchroniser feeds a counter.
  - Counter clears whenever the synchronised input equals the debounced level; otherwise it increments.
  - Level toggles on the edge at which the counter would reach DEBOUNCE_CYCLES; the counter then clears.
  - Total latency from a clean pin change to level change: 2+DEBOUNCE_CYCLES edges.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the level.
- Press flag: set on the edge where the debounced level rises 0->1. Cleared by a write to 0x14 with 1 in that bit position.
  - Simultaneous set and W1C on the same bit: set wins, flag stays 1.
- Writes: when we=1, the LED register updates at that edge and Led reflects it in the same cycle after the edge.
- Reads: re=1 at edge k -> rdata is valid and rvalid=1 after edge k+1, held for exactly one cycle.
  - When rvalid=0, rdata holds its last value.
  - Reads are non-destructive; BTN_PRESS is not read-to-clear.
- we and re asserted together: both are performed. A read of a register being written returns the pre-write value.
- Asynchronous reset mid-debounce discards counter progress; after release, a still-pressed button needs the full 2+DEBOUNCE_CYCLES again.

Optional Feature:
Macro MMIO_IO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and register 0x18 IRQ_MASK (RW, bits [NUM_BTN-1:0], reset 0).
  - irq = OR over (BTN_PRESS & IRQ_MASK), registered, asserting one cycle after the flag sets.
  - irq deasserts one cycle after the last masked flag clears.
- Undefined: no irq port; 0x18 is unmapped (reads 0).

Decomposition:
- Package mmio_io_pkg: offset constants (OFFS_SW, OFFS_BTN_LEVEL, OFFS_BTN_PRESS, OFFS_IRQ_MASK, OFFS_LED) and the bank stride constant.
- Sub-module io_debounce: one instance per button, containing synchroniser, counter and level. Parameter DEBOUNCE_CYCLES; outputs level and rise pulse.

Test Plan:
- Reset release, NUM_SW_BANKS=2, Switch=16'h0900, read 0x04 -> rdata=32'h09 with rvalid one cycle after re; read 0x00 -> 32'h00.
- DEBOUNCE_CYCLES=4, Button[0] held high -> BTN_LEVEL bit0=1 exactly 6 edges after the pin change; BTN_PRESS=32'h1.
- Button[0] high for 3 cycles then low -> BTN_LEVEL and BTN_PRESS stay 0.
- BTN_PRESS=1: write 0x14 with wdata=1 -> flag clears. Repeat with W1C on the same edge as a new rise -> flag stays 1.
- Write 0x20 wdata=32'hA5 -> Led[7:0]=8'hA5. Read 0x20 -> 32'hA5. Write to 0x2C with NUM_LED_BANKS=1 -> no change; read returns 0.
- Assert reset while Button is held with the counter at 3 -> level=0; after release, the level rises 6 edges later. With MMIO_IO_IRQ_EN and IRQ_MASK=1, irq rises one cycle after the press flag.
